// File: rtl/idex_stage.sv
// ID/EX pipeline register for the pipelined LEGv8 core.
// It also detects load-use hazards, inserts bubbles and counts stall cycles.
module idex_stage #(
  parameter int unsigned OPCODESIZE  = 11,
  parameter int unsigned REGADDRSIZE = 5,
  parameter int unsigned WORDSIZE    = 64,
  parameter int unsigned XZR         = 31,
  parameter int unsigned CNTSIZE     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [OPCODESIZE-1:0]  id_opcode,
  input  logic [REGADDRSIZE-1:0] id_ra,
  input  logic [REGADDRSIZE-1:0] id_rb,
  input  logic [REGADDRSIZE-1:0] id_rd,
  input  logic                   id_usesa,
  input  logic                   id_usesb,
  input  logic                   id_regwrite,
  input  logic                   id_memread,
  input  logic                   id_memwrite,
  input  logic [WORDSIZE-1:0]    id_dataa,
  input  logic [WORDSIZE-1:0]    id_datab,
  input  logic [WORDSIZE-1:0]    id_imm,
  input  logic [WORDSIZE-1:0]    id_pc,
  input  logic                   flush,
  output logic                   stall,
  output logic                   idex_valid,
  output logic [OPCODESIZE-1:0]  idex_opcode,
  output logic [REGADDRSIZE-1:0] idex_ra,
  output logic [REGADDRSIZE-1:0] idex_rb,
  output logic [REGADDRSIZE-1:0] idex_rd,
  output logic                   idex_regwrite,
  output logic                   idex_memread,
  output logic                   idex_memwrite,
  output logic [WORDSIZE-1:0]    idex_dataa,
  output logic [WORDSIZE-1:0]    idex_datab,
  output logic [WORDSIZE-1:0]    idex_imm,
  output logic [WORDSIZE-1:0]    idex_pc,
  output logic [CNTSIZE-1:0]     stall_cycles
);

  localparam logic [REGADDRSIZE-1:0] XzrIdx = REGADDRSIZE'(XZR);

  logic                   valid_q, valid_d;
  logic [OPCODESIZE-1:0]  opcode_q, opcode_d;
  logic [REGADDRSIZE-1:0] ra_q, ra_d;
  logic [REGADDRSIZE-1:0] rb_q, rb_d;
  logic [REGADDRSIZE-1:0] rd_q, rd_d;
  logic                   regwrite_q, regwrite_d;
  logic                   memread_q, memread_d;
  logic                   memwrite_q, memwrite_d;
  logic [WORDSIZE-1:0]    dataa_q, dataa_d;
  logic [WORDSIZE-1:0]    datab_q, datab_d;
  logic [WORDSIZE-1:0]    imm_q, imm_d;
  logic [WORDSIZE-1:0]    pc_q, pc_d;
  logic [CNTSIZE-1:0]     cnt_q, cnt_d;

  logic hazard_a, hazard_b, load_in_ex, capture;

  // Only a live load with a real destination can create a load-use hazard.
  assign load_in_ex = valid_q && memread_q && (rd_q != XzrIdx);
  assign hazard_a   = id_usesa && (id_ra == rd_q);
  assign hazard_b   = id_usesb && (id_rb == rd_q);
  assign stall      = !flush && id_valid && load_in_ex && (hazard_a || hazard_b);
  assign capture    = !flush && !stall && id_valid;

  always_comb begin
    valid_d    = 1'b0;
    opcode_d   = '0;
    ra_d       = '0;
    rb_d       = '0;
    rd_d       = XzrIdx;
    regwrite_d = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    dataa_d    = '0;
    datab_d    = '0;
    imm_d      = '0;
    pc_d       = '0;
    if (capture) begin
      valid_d    = 1'b1;
      opcode_d   = id_opcode;
      ra_d       = id_ra;
      rb_d       = id_rb;
      rd_d       = id_rd;
      regwrite_d = id_regwrite;
      memread_d  = id_memread;
      memwrite_d = id_memwrite;
      dataa_d    = id_dataa;
      datab_d    = id_datab;
      imm_d      = id_imm;
      pc_d       = id_pc;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNTSIZE'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      opcode_q   <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      rd_q       <= XzrIdx;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      dataa_q    <= '0;
      datab_q    <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      opcode_q   <= opcode_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      dataa_q    <= dataa_d;
      datab_q    <= datab_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign idex_valid    = valid_q;
  assign idex_opcode   = opcode_q;
  assign idex_ra       = ra_q;
  assign idex_rb       = rb_q;
  assign idex_rd       = rd_q;
  assign idex_regwrite = regwrite_q;
  assign idex_memread  = memread_q;
  assign idex_memwrite = memwrite_q;
  assign idex_dataa    = dataa_q;
  assign idex_datab    = datab_q;
  assign idex_imm      = imm_q;
  assign idex_pc       = pc_q;
  assign stall_cycles  = cnt_q;

endmodule

// File: doc/idex_stage.md
Name: idex_stage

Overview:
- ID/EX pipeline register of the pipelined LEGv8 core, with built-in load-use hazard detection.
- Captures the decoded instruction from ID and presents the registered idex_* fields to EX, the forwarding unit and the downstream EX/MEM register.
- Stalls the front end for one cycle and inserts a bubble when a load in ID/EX feeds the instruction in ID.
- Squashes its contents on a taken-branch flush and keeps a saturating stall-cycle counter.

Parameters:
- OPCODESIZE, 11, opcode width.
- REGADDRSIZE, 5, register address width.
- WORDSIZE, 64, datapath width.
- XZR, 31, zero-register index.
- CNTSIZE, 32, stall counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- id_valid  input  1  ID holds a real instruction.
- id_opcode  input  OPCODESIZE  decoded opcode.
- id_ra  input  REGADDRSIZE  first source register.
- id_rb  input  REGADDRSIZE  second source register.
- id_rd  input  REGADDRSIZE  destination register.
- id_usesa  input  1  instruction reads id_ra.
- id_usesb  input  1  instruction reads id_rb.
- id_regwrite  input  1  register-write control bit.
- id_memread  input  1  memory-read control bit.
- id_memwrite  input  1  memory-write control bit.
- id_dataa  input  WORDSIZE  register file read data A.
- id_datab  input  WORDSIZE  register file read data B.
- id_imm  input  WORDSIZE  sign-extended immediate.
- id_pc  input  WORDSIZE  instruction PC.
- flush  input  1  taken branch resolved downstream; squash ID/EX.
- stall  output  1  hold PC and IF/ID this cycle.
- idex_valid, idex_opcode, idex_ra, idex_rb, idex_rd, idex_regwrite, idex_memread, idex_memwrite, idex_dataa, idex_datab, idex_imm, idex_pc  output  (widths as the id_* ports)  registered copies of the id_* fields.
- stall_cycles  output  CNTSIZE  number of stall cycles since reset.

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high.
- Bubble value: valid=0, opcode=0, ra=0, rb=0, rd=XZR, regwrite=0, memread=0, memwrite=0, data/imm/pc=0.
- Reset values: all idex_* outputs take the bubble value; stall_cycles=0; stall therefore reads 0 after reset.
- Stall (combinational, depends only on id_* inputs, flush and registered idex_* state):
  - stall = !flush && id_valid && idex_valid && idex_memread && idex_rd!=XZR && ((id_usesa && id_ra==idex_rd) || (id_usesb && id_rb==idex_rd)).
- Register update each rising edge, priority order:
  - rst -> bubble.
  - else flush -> bubble.
  - else stall -> bubble. The ID instruction is held upstream and re-presented next cycle.
  - else !id_valid -> bubble.
  - else capture all id_* fields.
- Latency: exactly 1 cycle from ID inputs to idex_* outputs. No combinational path from id_* to idex_*.
- Stall length: a load-use stall lasts exactly one cycle. The inserted bubble clears idex_memread, so the repeated instruction is captured on the next edge, and the load result reaches it through MEM/WB forwarding.
- No stall cases:
  - back-to-back load to the same rd with no consumer;
  - load with rd=XZR;
  - a match on a source the instruction does not use (usesa/usesb=0).
- A load whose rd equals both id_ra and id_rb produces a single stall cycle.
- Flush with a coincident hazard: stall output forced 0, bubble captured, counter not incremented.
- stall_cycles:
  - increments by 1 on each edge where !rst && stall;
  - saturates at all-ones (no wrap);
  - cleared only by rst.
- Reset mid-stall: bubble captured, stall=0 from the next cycle, counter=0.
- The block never writes bubbles with regwrite=1. Downstream forwarding relies on regwrite=0 / rd=XZR in bubbles.

Test Plan:
- Reset: hold rst 2 cycles with id_valid=1 -> idex_valid=0, idex_rd=31, idex_regwrite=0, stall=0, stall_cycles=0.
- Capture: ADD X3,X1,X2 (ra=1, rb=2, rd=3, regwrite=1, usesa=usesb=1) -> next cycle idex_ra=1, idex_rb=2, idex_rd=3, idex_regwrite=1, idex_valid=1, stall=0.
- Load-use: LDUR X5 captured, then ADD X6,X5,X2 presented -> stall=1 for one cycle, next idex_valid=0; following cycle idex_rd=6, stall=0, stall_cycles=1.
- Non-hazards, each -> stall=0 throughout and stall_cycles unchanged:
  - LDUR X31 followed by a reader of X31;
  - LDUR X5 followed by CBZ-style id_rb=5 with usesb=0.
- Flush during hazard: LDUR X5 in ID/EX, consumer of X5 in ID, flush=1 -> stall=0, bubble captured, stall_cycles unchanged.
- Saturation with CNTSIZE=2: four consecutive load-use pairs -> stall_cycles reads 1, 2, 3, 3.
